switch_event_ctrl: RTL and testbench
====================================

Name: switch_event_ctrl

Overview:
- Turns debounced footswitch levels from the per-switch debouncer into effect-enable states and a single stream of switch events.
- Per switch: short press toggles a latched enable; long hold gives momentary inversion of that enable.
- Events are reported one at a time to the control logic over a valid/ready port.
- A round-robin arbiter shares that event port between all switches.

Parameters:
- NUM, 2, number of switches
- LONG_CYCLES, 24000000, hold length in clk_i cycles that turns a press into a long press; must be >= 2
- CNT_W, 25, hold-counter width; must satisfy 2**CNT_W > LONG_CYCLES
- INIT_EN, '0 (NUM bits), reset value of toggle_o
- ID_W, (NUM>1 ? $clog2(NUM) : 1), width of evt_id_o

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- sw_i  in  NUM  debounced switch levels, 1 = pressed, synchronous to clk_i
- toggle_o  out  NUM  latched enable per switch
- active_o  out  NUM  effective enable = toggle_o XOR momentary
- evt_valid_o  out  1  event available
- evt_ready_i  in  1  consumer accepts event
- evt_id_o  out  ID_W  switch index of the event
- evt_type_o  out  2  event type: 0 SHORT, 1 LONG_START, 2 LONG_END (3 never driven)

Behaviour:
- Reset (async assert, sync deassert by the reset source) drives:
  - toggle_o = INIT_EN, active_o = INIT_EN
  - all FSMs to IDLE, counters to 0, pending flags to 0
  - evt_valid_o = 0, evt_id_o = 0, evt_type_o = 0, round-robin pointer = 0
- Per-switch FSM, states IDLE, HOLD, LONG; cnt counts cycles spent in HOLD:
  - IDLE: sw_i=1 -> HOLD, cnt=0.
  - HOLD, sw_i=0 -> IDLE, toggle_o flips, raise SHORT.
  - HOLD, sw_i=1 and cnt==LONG_CYCLES-1 -> LONG, raise LONG_START.
  - HOLD, otherwise -> cnt+1.
  - LONG: momentary=1, so active_o = ~toggle_o. sw_i=0 -> IDLE, momentary=0, raise LONG_END.
  - Release exactly on the cycle the threshold is reached: release wins, giving SHORT.
- All outputs are registered. toggle_o and active_o change on the same edge as the FSM transition, i.e. 1 cycle after the sw_i change is sampled.
- Pending slots:
  - One slot per switch, holding a flag and a type.
  - A raised event is written into the slot on the transition edge.
  - An event raised while the slot is already full overwrites the type (newest wins; the old event is lost).
  - If an event is raised on the same edge its slot is being granted, the set wins: the slot stays pending with the new type.
- Arbiter / output register:
  - The output slot is free when evt_valid_o=0, or when evt_valid_o & evt_ready_i.
  - On a free edge with any slot pending: grant the first pending index at or after the pointer (wrapping), load evt_id_o/evt_type_o, set evt_valid_o=1, clear that slot, pointer = grant+1 mod NUM.
  - On a free edge with nothing pending: evt_valid_o=0.
  - While evt_valid_o=1 and evt_ready_i=0: evt_id_o and evt_type_o hold stable.
  - Latency from the sw_i sample edge: slot set at edge +1, evt_valid_o high at edge +2 if the output is free.
  - Back-to-back acceptance sustains 1 event per cycle.
- evt_ready_i has no effect on the FSMs or on toggle_o/active_o; a stalled consumer never blocks switch handling.
- Reset asserted mid-hold or mid-handshake discards all state with no event emitted.

Optional Feature:
- Macro: SWITCH_EVT_DROP_CNT_EN
- Defined:
  - Adds output port drop_cnt_o, out, 8 bits: a saturating count of events lost by slot overwrite, stopping at 255.
  - Incremented on each edge where an event is raised into a pending slot that is not being granted on the same edge.
  - Reset value 0.
- Undefined: port and logic absent; overwrite behaviour unchanged.

Test Plan (NUM=2, LONG_CYCLES=16, evt_ready_i=1 unless stated):
- sw_i[0] high for 5 cycles then low -> toggle_o[0] 0->1 one cycle after the release; one event id=0 type=0; active_o[0]=1.
- sw_i[1] held 40 cycles -> LONG_START (id=1, type=1) 16 cycles after press, active_o[1]=1 while held with toggle_o[1]=0; on release LONG_END (type=2), active_o[1]=0, toggle_o[1] unchanged.
- Release on the exact cycle cnt reaches 15 -> SHORT only, no LONG_START.
- Both switches short-pressed and released on the same cycle, pointer=0 -> id=0 then id=1 on consecutive cycles; next simultaneous pair -> id=0 first again (pointer wrapped to 0 after grant 1).
- evt_ready_i=0, switch 0 does SHORT, then a second SHORT (slot already granted, so two outputs queued: first in output register, second pending) -> output stable at the first event; after ready, the second follows; toggle_o[0] back to 0. With the macro defined, a third event before drain -> drop_cnt_o=1.
- Assert rst_n_i during LONG hold -> active_o = INIT_EN immediately (async); no LONG_END after release.

Source files
------------

// File: rtl/switch_event_ctrl.sv
// Footswitch event controller: short press toggles, long hold inverts momentarily,
// events are arbitrated round-robin onto one valid/ready port. Optional: SWITCH_EVT_DROP_CNT_EN.
module switch_event_ctrl #(
  parameter int              NUM         = 2,
  parameter int              LONG_CYCLES = 24000000,
  parameter int              CNT_W       = 25,
  parameter logic [NUM-1:0]  INIT_EN     = '0,
  parameter int              ID_W        = (NUM > 1) ? $clog2(NUM) : 1
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic [NUM-1:0]  sw_i,
  output logic [NUM-1:0]  toggle_o,
  output logic [NUM-1:0]  active_o,
  output logic            evt_valid_o,
  input  logic            evt_ready_i,
  output logic [ID_W-1:0] evt_id_o,
  output logic [1:0]      evt_type_o
`ifdef SWITCH_EVT_DROP_CNT_EN
  ,
  output logic [7:0]      drop_cnt_o
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_LONG = 2'd2;

  localparam logic [1:0] EV_SHORT      = 2'd0;
  localparam logic [1:0] EV_LONG_START = 2'd1;
  localparam logic [1:0] EV_LONG_END   = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LONG_CYCLES - 1);

  logic [1:0]       state_q [NUM];
  logic [1:0]       state_d [NUM];
  logic [CNT_W-1:0] cnt_q   [NUM];
  logic [CNT_W-1:0] cnt_d   [NUM];
  logic [NUM-1:0]   toggle_d;
  logic [NUM-1:0]   mom_d;
  logic [NUM-1:0]   raise;
  logic [1:0]       raise_type [NUM];

  logic [NUM-1:0]   pend_q;
  logic [NUM-1:0]   pend_d;
  logic [1:0]       ptype_q [NUM];
  logic [1:0]       ptype_d [NUM];
  logic [ID_W-1:0]  ptr_q;
  logic [ID_W-1:0]  ptr_d;
  logic             grant_vld;
  logic [ID_W-1:0]  grant_idx;
  logic             out_free;
  logic             take;

  // Per-switch press FSM and hold counter.
  always_comb begin
    for (int i = 0; i < NUM; i++) begin
      // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
      state_d[i]    = state_q[i];
      cnt_d[i]      = cnt_q[i];
      toggle_d[i]   = toggle_o[i];
      raise[i]      = 1'b0;
      raise_type[i] = EV_SHORT;
      case (state_q[i])
        ST_IDLE: begin
          if (sw_i[i]) begin
            state_d[i] = ST_HOLD;
            cnt_d[i]   = '0;
          end
        end
        ST_HOLD: begin
          // Release is checked first so a release on the threshold cycle is a short press.
          if (!sw_i[i]) begin
            state_d[i]  = ST_IDLE;
            toggle_d[i] = ~toggle_o[i];
            raise[i]    = 1'b1;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i]    = ST_LONG;
            raise[i]      = 1'b1;
            raise_type[i] = EV_LONG_START;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        ST_LONG: begin
          if (!sw_i[i]) begin
            state_d[i]    = ST_IDLE;
            raise[i]      = 1'b1;
            raise_type[i] = EV_LONG_END;
          end
        end
        default: state_d[i] = ST_IDLE;
      endcase
      mom_d[i] = (state_d[i] == ST_LONG);
    end
  end

  // Round-robin search for the first pending slot at or after the pointer.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM) idx = idx - NUM;
      if (!grant_vld && pend_q[idx]) begin
        grant_vld = 1'b1;
        grant_idx = ID_W'(idx);
      end
    end
  end

  assign out_free = !evt_valid_o || evt_ready_i;
  assign take     = out_free && grant_vld;
  assign ptr_d    = (grant_idx == ID_W'(NUM - 1)) ? '0 : grant_idx + ID_W'(1);

  // A newly raised event always lands in its slot, even when that slot is granted this edge.
  always_comb begin
    for (int i = 0; i < NUM; i++) begin
      pend_d[i]  = pend_q[i];
      ptype_d[i] = ptype_q[i];
      if (raise[i]) begin
        pend_d[i]  = 1'b1;
        ptype_d[i] = raise_type[i];
      end else if (take && grant_idx == ID_W'(i)) begin
        pend_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      // NOTE: the per-switch arrays are a handful of flops, not a RAM, so they are reset like any other state.
      for (int i = 0; i < NUM; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
        ptype_q[i] <= EV_SHORT;
      end
      pend_q      <= '0;
      toggle_o    <= INIT_EN;
      active_o    <= INIT_EN;
      ptr_q       <= '0;
      evt_valid_o <= 1'b0;
      evt_id_o    <= '0;
      evt_type_o  <= EV_SHORT;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      for (int i = 0; i < NUM; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        ptype_q[i] <= ptype_d[i];
      end
      pend_q   <= pend_d;
      toggle_o <= toggle_d;
      active_o <= toggle_d ^ mom_d;
      if (take) begin
        evt_valid_o <= 1'b1;
        evt_id_o    <= grant_idx;
        evt_type_o  <= ptype_q[grant_idx];
        ptr_q       <= ptr_d;
      end else if (out_free) begin
        evt_valid_o <= 1'b0;
      end
    end
  end

`ifdef SWITCH_EVT_DROP_CNT_EN
  logic [7:0] drop_d;

  // Overwrites of a slot that is not drained on the same edge lose an event.
  always_comb begin
    int unsigned n;
    n = 0;
    for (int i = 0; i < NUM; i++) begin
      if (raise[i] && pend_q[i] && !(take && grant_idx == ID_W'(i))) n = n + 1;
    end
    if (32'(drop_cnt_o) + n > 32'd255) drop_d = 8'hFF;
    else                                drop_d = drop_cnt_o + 8'(n);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) drop_cnt_o <= '0;
    else          drop_cnt_o <= drop_d;
  end
`endif

endmodule

// File: tb/tb_switch_event_ctrl.sv
// Self-checking bench for switch_event_ctrl: directed scenarios plus randomized
// switch/ready traffic against a press-length based reference model.
module tb_switch_event_ctrl;

  localparam int NUM   = 2;
  localparam int LONG  = 16;
  localparam int CNT_W = 5;
  localparam int ID_W  = 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NUM-1:0]  sw;
  logic [NUM-1:0]  toggle;
  logic [NUM-1:0]  active;
  logic            valid;
  logic            ready;
  logic [ID_W-1:0] id;
  logic [1:0]      typ;
`ifdef SWITCH_EVT_DROP_CNT_EN
  logic [7:0]      drop;
`endif

  always #5 clk = ~clk;

  switch_event_ctrl #(
    .NUM(NUM), .LONG_CYCLES(LONG), .CNT_W(CNT_W), .INIT_EN('0), .ID_W(ID_W)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .sw_i(sw),
    .toggle_o(toggle), .active_o(active),
    .evt_valid_o(valid), .evt_ready_i(ready),
    .evt_id_o(id), .evt_type_o(typ)
`ifdef SWITCH_EVT_DROP_CNT_EN
    , .drop_cnt_o(drop)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference model: a switch is described by how many consecutive edges it has been seen pressed.
  int m_len   [NUM];
  bit m_tog   [NUM];
  bit m_pend  [NUM];
  int m_ptype [NUM];
  bit m_valid;
  int m_id, m_type, m_ptr, m_drop;

  task automatic model_reset();
    for (int i = 0; i < NUM; i++) begin
      m_len[i] = 0; m_tog[i] = 0; m_pend[i] = 0; m_ptype[i] = 0;
    end
    m_valid = 0; m_id = 0; m_type = 0; m_ptr = 0; m_drop = 0;
  endtask

  function automatic logic [NUM-1:0] m_tog_vec();
    logic [NUM-1:0] v;
    for (int i = 0; i < NUM; i++) v[i] = m_tog[i];
    return v;
  endfunction

  function automatic logic [NUM-1:0] m_act_vec();
    logic [NUM-1:0] v;
    for (int i = 0; i < NUM; i++) v[i] = m_tog[i] ^ (m_len[i] > LONG);
    return v;
  endfunction

  task automatic model_edge();
    int ev [NUM];
    int g;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int i = 0; i < NUM; i++) begin
      ev[i] = -1;
      if (sw[i]) begin
        m_len[i]++;
        if (m_len[i] == LONG + 1) ev[i] = 1;
      end else begin
        if (m_len[i] > LONG) ev[i] = 2;
        else if (m_len[i] > 0) begin ev[i] = 0; m_tog[i] = !m_tog[i]; end
        m_len[i] = 0;
      end
    end
    if (!m_valid || ready) begin
      g = -1;
      for (int k = 0; k < NUM; k++)
        if (g < 0 && m_pend[(m_ptr + k) % NUM]) g = (m_ptr + k) % NUM;
      if (g >= 0) begin
        m_valid = 1; m_id = g; m_type = m_ptype[g]; m_pend[g] = 0; m_ptr = (g + 1) % NUM;
      end else begin
        m_valid = 0;
      end
    end
    for (int i = 0; i < NUM; i++) begin
      if (ev[i] >= 0) begin
        if (m_pend[i] && m_drop < 255) m_drop++;
        m_pend[i] = 1; m_ptype[i] = ev[i];
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_reset();
    #1;
    total++; if (toggle !== 2'b00) begin bad++; $display("FAIL reset_toggle: got %b want 00", toggle); end
    total++; if (active !== 2'b00) begin bad++; $display("FAIL reset_active: got %b want 00", active); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid); end
    total++; if (id !== '0) begin bad++; $display("FAIL reset_id: got %0d want 0", id); end
    total++; if (typ !== 2'd0) begin bad++; $display("FAIL reset_type: got %0d want 0", typ); end
`ifdef SWITCH_EVT_DROP_CNT_EN
    total++; if (drop !== 8'd0) begin bad++; $display("FAIL reset_drop: got %0d want 0", drop); end
`endif
    model_reset();
    step(2);
    rst_n = 1'b1;
    step(1);
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL post_reset_valid: got %b want 0", valid); end
  endtask

  task automatic test_short();
    sw = 2'b01;
    step(5);
    total++; if (toggle[0] !== 1'b0) begin bad++; $display("FAIL short_hold_toggle: got %b want 0", toggle[0]); end
    sw = 2'b00;
    step(1);
    total++; if (toggle[0] !== 1'b1) begin bad++; $display("FAIL short_toggle: got %b want 1", toggle[0]); end
    total++; if (active[0] !== 1'b1) begin bad++; $display("FAIL short_active: got %b want 1", active[0]); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL short_valid_early: got %b want 0", valid); end
    step(1);
    total++; if ({valid, id, typ} !== {1'b1, 1'b0, 2'd0}) begin
      bad++; $display("FAIL short_event: got v=%b id=%0d t=%0d want v=1 id=0 t=0", valid, id, typ); end
    step(1);
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL short_single: got %b want 0", valid); end
  endtask

  task automatic test_long();
    sw = 2'b10;
    step(16);
    total++; if (active[1] !== 1'b0) begin bad++; $display("FAIL long_early_active: got %b want 0", active[1]); end
    step(1);
    total++; if (active[1] !== 1'b1) begin bad++; $display("FAIL long_active: got %b want 1", active[1]); end
    total++; if (toggle[1] !== 1'b0) begin bad++; $display("FAIL long_toggle: got %b want 0", toggle[1]); end
    step(1);
    total++; if ({valid, id, typ} !== {1'b1, 1'b1, 2'd1}) begin
      bad++; $display("FAIL long_start: got v=%b id=%0d t=%0d want v=1 id=1 t=1", valid, id, typ); end
    step(22);
    total++; if (active[1] !== 1'b1) begin bad++; $display("FAIL long_held_active: got %b want 1", active[1]); end
    sw = 2'b00;
    step(1);
    total++; if (active[1] !== 1'b0) begin bad++; $display("FAIL long_release_active: got %b want 0", active[1]); end
    total++; if (toggle[1] !== 1'b0) begin bad++; $display("FAIL long_release_toggle: got %b want 0", toggle[1]); end
    step(1);
    total++; if ({valid, id, typ} !== {1'b1, 1'b1, 2'd2}) begin
      bad++; $display("FAIL long_end: got v=%b id=%0d t=%0d want v=1 id=1 t=2", valid, id, typ); end
    step(1);
  endtask

  task automatic test_exact_threshold();
    sw = 2'b01;
    for (int c = 0; c < 16; c++) begin
      step(1);
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL exact_no_event: got %b want 0", valid); end
    end
    sw = 2'b00;
    step(1);
    total++; if (toggle[0] !== 1'b0) begin bad++; $display("FAIL exact_toggle: got %b want 0", toggle[0]); end
    total++; if (active[0] !== 1'b0) begin bad++; $display("FAIL exact_active: got %b want 0", active[0]); end
    step(1);
    total++; if ({valid, id, typ} !== {1'b1, 1'b0, 2'd0}) begin
      bad++; $display("FAIL exact_short: got v=%b id=%0d t=%0d want v=1 id=0 t=0", valid, id, typ); end
    step(1);
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL exact_single: got %b want 0", valid); end
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int pass = 0; pass < 2; pass++) begin
      sw = 2'b11;
      step(3);
      sw = 2'b00;
      step(2);
      total++; if ({valid, id, typ} !== {1'b1, 1'b0, 2'd0}) begin
        bad++; $display("FAIL rr_first[%0d]: got v=%b id=%0d t=%0d want v=1 id=0 t=0", pass, valid, id, typ); end
      step(1);
      total++; if ({valid, id, typ} !== {1'b1, 1'b1, 2'd0}) begin
        bad++; $display("FAIL rr_second[%0d]: got v=%b id=%0d t=%0d want v=1 id=1 t=0", pass, valid, id, typ); end
      step(1);
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL rr_drain[%0d]: got %b want 0", pass, valid); end
    end
    total++; if (toggle !== 2'b00) begin bad++; $display("FAIL rr_toggle: got %b want 00", toggle); end
  endtask

  task automatic test_stall();
    ready = 1'b0;
    sw = 2'b01; step(3); sw = 2'b00; step(1);
    total++; if (toggle[0] !== 1'b1) begin bad++; $display("FAIL stall_toggle1: got %b want 1", toggle[0]); end
    step(1);
    total++; if ({valid, id, typ} !== {1'b1, 1'b0, 2'd0}) begin
      bad++; $display("FAIL stall_first: got v=%b id=%0d t=%0d want v=1 id=0 t=0", valid, id, typ); end
    sw = 2'b01;
    for (int c = 0; c < 3; c++) begin
      step(1);
      total++; if ({valid, id, typ} !== {1'b1, 1'b0, 2'd0}) begin
        bad++; $display("FAIL stall_hold: got v=%b id=%0d t=%0d want v=1 id=0 t=0", valid, id, typ); end
    end
    sw = 2'b00; step(1);
    total++; if (toggle[0] !== 1'b0) begin bad++; $display("FAIL stall_toggle2: got %b want 0", toggle[0]); end
    sw = 2'b01; step(3); sw = 2'b00; step(1);
    total++; if (toggle[0] !== 1'b1) begin bad++; $display("FAIL stall_toggle3: got %b want 1", toggle[0]); end
`ifdef SWITCH_EVT_DROP_CNT_EN
    total++; if (drop !== 8'd1) begin bad++; $display("FAIL stall_drop: got %0d want 1", drop); end
`endif
    ready = 1'b1;
    step(1);
    total++; if ({valid, id, typ} !== {1'b1, 1'b0, 2'd0}) begin
      bad++; $display("FAIL stall_second: got v=%b id=%0d t=%0d want v=1 id=0 t=0", valid, id, typ); end
    step(1);
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL stall_drain: got %b want 0", valid); end
  endtask

  task automatic test_async_reset();
    ready = 1'b1;
    sw = 2'b10;
    step(18);
    total++; if (active[1] !== 1'b1) begin bad++; $display("FAIL areset_long_active: got %b want 1", active[1]); end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    total++; if (active !== 2'b00) begin bad++; $display("FAIL areset_active: got %b want 00", active); end
    total++; if (toggle !== 2'b00) begin bad++; $display("FAIL areset_toggle: got %b want 00", toggle); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL areset_valid: got %b want 0", valid); end
    sw = 2'b00;
    step(2);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step(1);
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL areset_no_event: got %b want 0", valid); end
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NUM; i++)
        if ($urandom_range(7) == 0) sw[i] = ~sw[i];
      ready = 1'($urandom_range(1));
      step(1);
      total++; if (toggle !== m_tog_vec()) begin
        bad++; $display("FAIL rnd_toggle@%0d: got %b want %b", c, toggle, m_tog_vec()); end
      total++; if (active !== m_act_vec()) begin
        bad++; $display("FAIL rnd_active@%0d: got %b want %b", c, active, m_act_vec()); end
      total++; if (valid !== m_valid) begin
        bad++; $display("FAIL rnd_valid@%0d: got %b want %b", c, valid, m_valid); end
      if (m_valid) begin
        total++; if ({id, typ} !== {ID_W'(m_id), 2'(m_type)}) begin
          bad++; $display("FAIL rnd_event@%0d: got id=%0d t=%0d want id=%0d t=%0d", c, id, typ, m_id, m_type); end
      end
`ifdef SWITCH_EVT_DROP_CNT_EN
      total++; if (drop !== 8'(m_drop)) begin
        bad++; $display("FAIL rnd_drop@%0d: got %0d want %0d", c, drop, m_drop); end
`endif
    end
  endtask

  initial begin
    rst_n = 1'b0;
    sw    = '0;
    ready = 1'b1;
    model_reset();
    test_reset();
    test_short();
    test_long();
    test_exact_threshold();
    test_round_robin();
    test_stall();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
